shifter_pipelined: RTL
======================

// Module: shifter_pipelined
// PURPOSE
//  Pipelined, parametrised barrel shifter for the ALU datapath.
//  Supports SLL, SRL, SRA, ROL and ROR.
//  Uses one register stage per shamt bit and a valid/ready handshake on both sides.
//  Sustains one result per cycle with full backpressure, so multi-cycle execute units can share it.
// PARAMETERS
//  N        32            operand width; must be a power of two, >= 4
//  SHAMT_W  $clog2(N)     shift-amount width (derived; do not override)
//  L        $clog2(N)     pipeline depth in stages (derived; equals SHAMT_W)
// PORTS
//  clk        input   1        single clock; all state updates on posedge
//  rst        input   1        asynchronous, active-high reset
//  flush      input   1        synchronous; discards all in-flight operations
//  in_valid   input   1        request valid
//  in_ready   output  1        request accepted when in_valid & in_ready at posedge
//  in_data    input   N        operand
//  in_shamt   input   SHAMT_W  shift amount, 0..N-1
//  in_mode    input   3        000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 pass-through
//  out_valid  output  1        result valid
//  out_ready  input   1        consumer accepts when out_valid & out_ready at posedge
//  out_data   output  N        shifted result
// BEHAVIOUR
//  - Reset (async, rst=1):
//    - all stage valid bits clear immediately; out_valid=0, out_data=0.
//    - in_ready=0 while rst=1; in_ready=1 on the first cycle after release.
//  - Structure: stages 0..L-1.
//    - Stage k applies a shift of 2^k when shamt[k]=1, else passes the data through.
//    - Each stage registers data, remaining shamt, mode and a valid bit.
//    - Stage L-1 drives out_*.
//  - Latency: exactly L cycles from acceptance to out_valid when unstalled (N=32 -> 5 cycles).
//  - Throughput: 1 op/cycle with no stalls.
//  - Handshake:
//    - ready_k = ~valid_k | ready_{k+1}; ready_L = out_ready; in_ready = ready_0 & ~flush.
//    - A stage loads from its predecessor only when ready_k is 1; otherwise it holds.
//    - Stalls are per-stage, so bubbles collapse: an empty stage accepts even when downstream is stalled.
//    - out_data and out_valid stay stable while out_valid & ~out_ready.
//    - in_valid may drop without acceptance; no ordering requirement on the producer.
//  - Arithmetic:
//    - SLL fills with 0; SRL fills with 0.
//    - SRA fills with the operand MSB captured at acceptance; the sign travels with the op.
//    - ROL/ROR wrap bits modulo N.
//    - shamt=0 returns the operand unchanged for every mode.
//    - Reserved modes return the operand unchanged.
//  - Ordering: results emerge strictly in acceptance order; there is no reordering or dropping except by flush/rst.
//  - flush=1 at posedge:
//    - all valid bits clear; out_valid=0 the next cycle.
//    - in_ready=0 while flush=1, so no request is accepted in that cycle.
//    - A simultaneous out handshake in the flush cycle still completes; the consumer saw it.
//  - Reset mid-operation: in-flight ops are lost silently; no stale out_valid after release.
//  - No combinational path from in_* to out_*.
//  - Combinational paths: out_ready -> in_ready and flush -> in_ready only.
// TESTING (N=32)
//  1. SRA 0x80000000 shamt=31 -> 0xFFFFFFFF; SRL same -> 0x00000001.
//     Both out_valid exactly 5 cycles after accept.
//  2. ROR 0x00000001 shamt=1 -> 0x80000000; ROL 0x80000001 shamt=4 -> 0x00000018.
//     SLL 0x00000001 shamt=31 -> 0x80000000; mode 111 on 0x1234ABCD -> 0x1234ABCD.
//  3. Backpressure: out_ready=0, in_valid=1 continuously with values 1..7 -> exactly 5 accepted.
//     in_ready=0 after that; out_data held.
//     Then out_ready=1 -> results 1..5 in order on consecutive cycles, then 6, 7.
//  4. Bubble collapse: 2 ops accepted with a 2-cycle gap, out_ready=0 for 4 cycles -> in_ready stays 1 until the pipe is full.
//     Both results delivered in order.
//  5. flush with 3 ops in flight plus in_valid=1 -> in_ready=0 that cycle.
//     out_valid=0 next cycle; no flushed op ever appears.
//     A new op accepted the following cycle returns after 5 cycles.
//     rst asserted mid-stream -> out_valid=0 asynchronously, out_data=0.
//  6. 2000 random ops (all modes, all shamt), random in_valid/out_ready.
//     Every result matches the reference model; count in == count out.

Source files
------------

// File: rtl/shifter_pipelined.sv
// shifter_pipelined: pipelined barrel shifter for the ALU datapath.
// Supports SLL, SRL, SRA, ROL and ROR. Stage k applies a shift of 2^k when
// bit k of the shift amount is set. Every stage carries its own valid bit, so
// stalls are per stage and bubbles collapse under backpressure.
module shifter_pipelined #(
  parameter int N       = 32,
  parameter int SHAMT_W = $clog2(N),
  parameter int L       = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_data
);

  // Operation encodings; anything above ROR passes the operand through.
  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // Per-stage registered state. Sign is captured once at acceptance and
  // travels with the op so SRA never has to re-derive it mid-pipe.
  logic [L-1:0]       valid_q;
  logic [N-1:0]       data_q  [L];
  logic [SHAMT_W-1:0] shamt_q [L];
  logic [2:0]         mode_q  [L];
  logic               sign_q  [L];

  // Stage inputs (from the request port for stage 0, otherwise from the
  // previous stage) and the shifted data each stage would load.
  logic [L-1:0]       stage_vin;
  logic [N-1:0]       stage_din   [L];
  logic [SHAMT_W-1:0] stage_shamt [L];
  logic [2:0]         stage_mode  [L];
  logic               stage_sign  [L];
  logic [N-1:0]       stage_dnext [L];

  // ready[k] is high when stage k may load a new op this cycle.
  logic [L-1:0]       ready;

  // Fixed-distance shift for one stage. Rotates wrap modulo N; SRA fills
  // the vacated upper bits with the sign captured at acceptance.
  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d,
                                            input logic [2:0]   m,
                                            input logic         sign,
                                            input int           amt);
    logic [N-1:0] r;
    r = d;
    case (m)
      MODE_SLL: r = d << amt;
      MODE_SRL: r = d >> amt;
      MODE_SRA: r = (d >> amt) | ((~({N{1'b1}} >> amt)) & {N{sign}});
      MODE_ROL: r = (d << amt) | (d >> (N - amt));
      MODE_ROR: r = (d >> amt) | (d << (N - amt));
      default:  r = d;
    endcase
    return r;
  endfunction

  // Ready chain: a stage can load if it is empty or if some stage between it
  // and the output is empty or the consumer is taking the result, which is
  // the unrolled form of ready_k = ~valid_k | ready_{k+1}.
  always_comb begin
    logic chain;
    ready = '0;
    chain = out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      chain    = chain | ~valid_q[k];
      ready[k] = chain;
    end
  end

  // Requests are refused while flushing or while held in reset.
  assign in_ready = ready[0] & ~flush & ~rst;

  // Route each stage's source: the request port feeds stage 0, every other
  // stage takes the registered contents of its predecessor.
  always_comb begin
    stage_vin[0]   = in_valid & in_ready;
    stage_din[0]   = in_data;
    stage_shamt[0] = in_shamt;
    stage_mode[0]  = in_mode;
    stage_sign[0]  = in_data[N-1];
    for (int k = 1; k < L; k++) begin
      stage_vin[k]   = valid_q[k-1];
      stage_din[k]   = data_q[k-1];
      stage_shamt[k] = shamt_q[k-1];
      stage_mode[k]  = mode_q[k-1];
      stage_sign[k]  = sign_q[k-1];
    end
  end

  // Each stage shifts by 2^k only when its own shift-amount bit is set.
  always_comb begin
    for (int k = 0; k < L; k++) begin
      stage_dnext[k] = stage_din[k];
      if (stage_shamt[k][k]) begin
        stage_dnext[k] = shift_by(stage_din[k], stage_mode[k], stage_sign[k], 1 << k);
      end
    end
  end

  // Valid bits: cleared by reset or flush, otherwise advance wherever a
  // stage is ready and hold where it is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (ready[k]) begin
          valid_q[k] <= stage_vin[k];
        end
      end
    end
  end

  // Payload registers load only when a real op moves in, so a stalled or
  // idle stage keeps its data steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        sign_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        if (ready[k] && stage_vin[k]) begin
          data_q[k]  <= stage_dnext[k];
          shamt_q[k] <= stage_shamt[k];
          mode_q[k]  <= stage_mode[k];
          sign_q[k]  <= stage_sign[k];
        end
      end
    end
  end

  assign out_valid = valid_q[L-1];
  assign out_data  = data_q[L-1];

endmodule
